// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// the FSM state encoding and the default operand width.
package mul_pkg;

  localparam int MUL_BITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul_seq_if.sv
// Handshake and operand/product bundle for mul_seq. The ovf signal
// is present only when MUL_OVF_EN is defined.
interface mul_seq_if #(parameter int BITS = mul_pkg::MUL_BITS);

  logic            start;
  logic [0:BITS-1] a;
  logic [0:BITS-1] b;
  logic            busy;
  logic            done;
  logic [0:BITS-1] prod_hi;
  logic [0:BITS-1] prod_lo;
`ifdef MUL_OVF_EN
  logic            ovf;

  modport master (output start, a, b, input busy, done, prod_hi, prod_lo, ovf);
  modport slave  (input start, a, b, output busy, done, prod_hi, prod_lo, ovf);
`else
  modport master (output start, a, b, input busy, done, prod_hi, prod_lo);
  modport slave  (input start, a, b, output busy, done, prod_hi, prod_lo);
`endif

endinterface

// File: rtl/mul_seq_adder.sv
// BITS-wide ripple adder with carry in/out; bit 0 is the MSB of each operand.
module adder_n #(
  parameter int BITS = mul_pkg::MUL_BITS
) (
  input  logic [0:BITS-1] i_a,
  input  logic [0:BITS-1] i_b,
  input  logic            i_cin,
  output logic [0:BITS-1] o_s,
  output logic            o_c
);

  logic [BITS:0] w_sum;

  assign w_sum    = {1'b0, i_a} + {1'b0, i_b} + {{BITS{1'b0}}, i_cin};
  assign {o_c, o_s} = w_sum;

endmodule

// File: rtl/mul_seq.sv
// Sequential unsigned multiplier: one shift-add step per clock using a single adder_n.
// Define MUL_OVF_EN to add the ovf output (upper product half non-zero).
module mul_seq
  import mul_pkg::*;
#(
  parameter int BITS = MUL_BITS
) (
  input  logic     clk,
  input  logic     rst_n,
  mul_seq_if.slave bus
);

  localparam int CW = $clog2(BITS);

  state_t          r_state;
  state_t          w_next;
  logic            w_load;
  logic [0:BITS-1] r_mcand;
  logic [0:BITS-1] r_acc;
  logic [0:BITS-1] r_mq;
  logic [CW-1:0]   r_cnt;
  logic [0:BITS-1] w_addend;
  logic [0:BITS-1] w_sum;
  logic            w_carry;

  // mq[BITS-1] is the multiplier LSB still to be consumed this step
  assign w_addend = r_mq[BITS-1] ? r_mcand : '0;

  adder_n #(.BITS(BITS)) u_adder (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_s   (w_sum),
    .o_c   (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
      RUN: begin
        if (r_cnt == '0) w_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          w_next = RUN;
          w_load = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // The carry enters at the top of acc so the full product survives the shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_mcand <= bus.a;
      r_mq    <= bus.b;
      r_acc   <= '0;
      r_cnt   <= CW'(BITS - 1);
    end else if (r_state == RUN) begin
      {r_acc, r_mq} <= {w_carry, w_sum, r_mq[0:BITS-2]};
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
  end

  assign bus.busy    = (r_state == RUN);
  assign bus.done    = (r_state == DONE);
  assign bus.prod_hi = r_acc;
  assign bus.prod_lo = r_mq;
`ifdef MUL_OVF_EN
  assign bus.ovf     = (r_state != RUN) && (r_acc != '0);
`endif

endmodule

// File: tb/tb_mul_seq.sv
// Randomised self-checking bench for mul_seq against a plain a*b reference.
// Checks ovf as well when MUL_OVF_EN is defined.
module tb_mul_seq;

  localparam int BITS = 32;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   failCount;
  int   cycleCount;
  int   startEdge;

  mul_seq_if #(.BITS(BITS)) bus_if ();

  mul_seq #(.BITS(BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands with start for one edge, then scramble a/b
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
    bus_if.a     = av;
    bus_if.b     = bv;
    bus_if.start = 1'b1;
    @(negedge clk);
    startEdge    = cycleCount;
    bus_if.start = 1'b0;
    bus_if.a     = $urandom;
    bus_if.b     = $urandom;
  endtask

  task automatic waitDone(input string tag);
    int guard;
    guard = 0;
    while (bus_if.done !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_latency"}, 64'(cycleCount - startEdge), 64'(BITS));
  endtask

  task automatic checkResult(input string tag, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] prod;
    prod = 64'(av) * 64'(bv);
    checkOutput({tag, "_hi"}, 64'(bus_if.prod_hi), 64'(prod[63:32]));
    checkOutput({tag, "_lo"}, 64'(bus_if.prod_lo), 64'(prod[31:0]));
`ifdef MUL_OVF_EN
    checkOutput({tag, "_ovf"}, 64'(bus_if.ovf), 64'(prod[63:32] != 32'd0));
`endif
  endtask

  task automatic runOne(input string tag, input logic [31:0] av, input logic [31:0] bv);
    applyStimulus(av, bv);
    checkOutput({tag, "_busy"}, 64'(bus_if.busy), 64'd1);
    waitDone(tag);
    checkResult(tag, av, bv);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(bus_if.done), 64'd0);
    checkOutput({tag, "_idle_busy"}, 64'(bus_if.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int doneSeen;
    checkCount   = 0;
    failCount    = 0;
    cycleCount   = 0;
    startEdge    = 0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(bus_if.busy), 64'd0);
    checkOutput("reset_done", 64'(bus_if.done), 64'd0);
    checkOutput("reset_hi", 64'(bus_if.prod_hi), 64'd0);
    checkOutput("reset_lo", 64'(bus_if.prod_lo), 64'd0);
`ifdef MUL_OVF_EN
    checkOutput("reset_ovf", 64'(bus_if.ovf), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    runOne("three_x_five", 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    checkResult("hold_in_idle", 32'd3, 32'd5);

    runOne("max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Start re-pulsed mid-run with other operands must be ignored
    applyStimulus(32'h0001_0000, 32'h0001_0000);
`ifdef MUL_OVF_EN
    checkOutput("run_ovf_low", 64'(bus_if.ovf), 64'd0);
`endif
    repeat (9) @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 32'h1234_5678;
    bus_if.b     = 32'h9ABC_DEF0;
    @(negedge clk);
    bus_if.start = 1'b0;
    waitDone("repulse");
    checkResult("repulse", 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);

    // Back-to-back: start held high throughout, new operands at DONE
    bus_if.a     = 32'd11;
    bus_if.b     = 32'd13;
    bus_if.start = 1'b1;
    @(negedge clk);
    startEdge = cycleCount;
    while (bus_if.done !== 1'b1 && (cycleCount - startEdge) < 200) begin
      bus_if.a = $urandom;
      bus_if.b = $urandom;
      @(negedge clk);
    end
    checkOutput("b2b_first_latency", 64'(cycleCount - startEdge), 64'(BITS));
    checkResult("b2b_first", 32'd11, 32'd13);
    checkOutput("b2b_gap_busy", 64'(bus_if.busy), 64'd0);
    bus_if.a = 32'd7;
    bus_if.b = 32'd6;
    @(negedge clk);
    startEdge    = cycleCount;
    bus_if.start = 1'b0;
    checkOutput("b2b_rebusy", 64'(bus_if.busy), 64'd1);
    waitDone("b2b_second");
    checkResult("b2b_second", 32'd7, 32'd6);
    @(negedge clk);

    // Reset in the middle of a run aborts it
    applyStimulus(32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(bus_if.busy), 64'd0);
    checkOutput("abort_done", 64'(bus_if.done), 64'd0);
    checkOutput("abort_hi", 64'(bus_if.prod_hi), 64'd0);
    checkOutput("abort_lo", 64'(bus_if.prod_lo), 64'd0);
`ifdef MUL_OVF_EN
    checkOutput("abort_ovf", 64'(bus_if.ovf), 64'd0);
`endif
    doneSeen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) doneSeen++;
    end
    checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
    rst_n = 1'b1;
    runOne("zero_x_nine", 32'd0, 32'd9);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'd0;
      if (i == 1) rb = 32'hFFFF_FFFF;
      if (i == 2) begin ra = 32'd1; rb = $urandom_range(1, 1000); end
      runOne($sformatf("rand%0d", i), ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter: BITS, default 32, operand width; the product is 2*BITS wide.
REQ-002 Clock: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request to begin a multiply; sampled on clk rise.
REQ-006 a  in  [0:BITS-1]  multiplicand; bit 0 is MSB.
REQ-007 b  in  [0:BITS-1]  multiplier; bit 0 is MSB.
REQ-008 busy  out  1  high while a multiply is in progress.
REQ-009 done  out  1  one-cycle pulse; product is valid.
REQ-010 prod_hi  out  [0:BITS-1]  upper half of the unsigned product.
REQ-011 prod_lo  out  [0:BITS-1]  lower half of the unsigned product.
REQ-012 ovf  out  1  exists only with MUL_OVF_EN; see Configuration.

Function
REQ-013 The block SHALL compute the unsigned product a*b by iterative shift-add, using one shared adder_n instance with cin tied to 0.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE/DONE with start=1 -> RUN, and the block SHALL latch a into mcand, b into mq, clear acc to 0, and set cnt to BITS-1.
REQ-016 DONE with start=0 -> IDLE; DONE lasts exactly one cycle.
REQ-017 Each RUN cycle SHALL compute {c,s} = adder_n(acc, mq[BITS-1] ? mcand : 0) and then load {acc, mq} <= {c, s, mq[0:BITS-2]}, a right shift by one of the BITS*2+1 value.
REQ-018 In RUN with cnt==0, the step SHALL execute and the FSM SHALL go RUN -> DONE; otherwise cnt SHALL decrement by 1.
REQ-019 Latency SHALL be BITS cycles: for start sampled at edge E, done=1 in the cycle following edge E+BITS.
REQ-020 busy SHALL equal (state==RUN).
REQ-021 done SHALL equal (state==DONE).
REQ-022 prod_hi/prod_lo SHALL equal acc/mq, and SHALL hold their value in IDLE until the next accepted start.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the operation or on the operands.
REQ-024 start in the DONE cycle SHALL be accepted: back-to-back operation with no idle gap.
REQ-025 Changes on a and b SHALL have no effect after the start cycle.
REQ-026 Corner cases: 0*x=0; (2^BITS-1)^2 SHALL yield prod_hi=2^BITS-2 and prod_lo=1, with the adder carry captured every step.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, acc=0, mq=0, mcand=0, cnt=0 and ovf=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the block SHALL be in IDLE and accept start on the first edge.

Configuration
REQ-029 With macro MUL_OVF_EN defined, port ovf SHALL exist and equal (prod_hi != 0) in DONE and IDLE, and 0 in RUN.
REQ-030 Without MUL_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Shared package mul_pkg SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default width constant MUL_BITS=32.
REQ-032 The single sub-module SHALL be adder_n #(.BITS(BITS)); there SHALL be no other adders in mul_seq.
REQ-033 The counter width SHALL be $clog2(BITS).

Verification
REQ-034 a=3, b=5, start pulse -> done exactly 32 cycles after the start edge, prod_hi=0, prod_lo=15, ovf=0.
REQ-035 a=b=32'hFFFFFFFF -> prod_hi=32'hFFFFFFFE, prod_lo=32'h00000001, ovf=1.
REQ-036 a=32'h00010000, b=32'h00010000 -> prod_hi=1, prod_lo=0; start re-pulsed at cycle 10 -> ignored, result unchanged.
REQ-037 Back-to-back: start held high through DONE with new a=7, b=6 -> second done 32 cycles later, prod_lo=42, busy low for 1 cycle only.
REQ-038 rst_n pulsed low at cycle 15 of RUN -> no done, all outputs 0; next start with a=0, b=9 -> prod=0.
